hazard_unit: RTL

Per-cycle hazard detection for the 5-stage pipeline (index 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB). Produces the stall, flush and extend vectors consumed directly by the pipeline bubble controller. Covers load-use stalls, EX-resolved branch/jump redirects, multi-cycle mul/div occupancy of EX, MEM wait-states and MEM exceptions. Sequential content: the mul/div occupancy FSM and its cycle counter.

---
 rtl/hazard_unit_pkg.sv | 39 +++
 rtl/hazard_unit_if.sv | 42 ++++
 rtl/hazard_unit_muldiv_tracker.sv | 83 ++++++++
 rtl/hazard_unit.sv | 75 +++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: stage indices, the
// stage-vector type, the mul/div tracker state encoding and a helper that
// turns a flush vector into the set of stages it kills.
package hazard_unit_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int STG_N   = 5;

  typedef logic [STG_N-1:0] stg_vec_t;

  // Wide enough for the largest legal MULDIV_CYCLES (255).
  localparam int MD_CNT_W = 8;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // A flush of stage k kills every stage from IF up to and including k, so
  // the mask has bit j set whenever some flush[k] with k >= j is set.
  function automatic stg_vec_t flush_kill_mask(stg_vec_t flush);
    stg_vec_t mask;
    mask = '0;
    for (int k = 0; k < STG_N; k++) begin
      if (flush[k]) begin
        for (int j = 0; j <= k; j++) begin
          mask[j] = 1'b1;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline and the hazard unit: per-stage status going in,
// stall/flush/extend request vectors and the mul/div busy flag coming out.
interface hazard_unit_if #(
  parameter int REG_W = 5
);
  import hazard_unit_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_dest;
  logic             ex_redirect;
  logic             ex_muldiv;
  logic             mem_valid;
  logic             mem_access;
  logic             mem_ready;
  logic             mem_exc;
  stg_vec_t         stall;
  stg_vec_t         flush;
  stg_vec_t         extend;
  logic             md_busy;

  // Pipeline side: reports stage contents, consumes the request vectors.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt,
    output ex_valid, ex_is_load, ex_dest, ex_redirect, ex_muldiv,
    output mem_valid, mem_access, mem_ready, mem_exc,
    input  stall, flush, extend, md_busy
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt,
    input  ex_valid, ex_is_load, ex_dest, ex_redirect, ex_muldiv,
    input  mem_valid, mem_access, mem_ready, mem_exc,
    output stall, flush, extend, md_busy
  );

endinterface

// File: rtl/hazard_unit_muldiv_tracker.sv
// Tracks how long a mul/div op has occupied EX. IDLE sees the op arrive,
// BUSY counts down the remaining extension cycles, DONE is the final EX cycle
// and waits there until MEM lets EX advance.
module muldiv_tracker
  import hazard_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,    // mul/div present in EX
  input  logic advance,  // EX hands its instruction on this cycle
  input  logic kill,     // MEM exception flushes EX
  output logic ext_req,  // hold EX for another cycle
  output logic busy
);

  // BUSY spans MULDIV_CYCLES-2 cycles; the IDLE arrival cycle and the DONE
  // cycle make up the rest of the occupancy.
  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MULDIV_CYCLES - 2);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);
  // A two-cycle op has no BUSY phase at all.
  localparam md_state_t START_STATE = (MULDIV_CYCLES == 2) ? MD_DONE : MD_BUSY;

  md_state_t           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge value of every other flop regardless of block order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and extension request.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_req = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        ext_req = start;
        if (start) begin
          state_d = START_STATE;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        ext_req = 1'b1;
        busy    = 1'b1;
        // Counts through MEM wait-states too: the op keeps computing.
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        if (advance) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
    // An exception in MEM wipes out the op in EX whatever phase it was in.
    if (kill) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Per-cycle hazard detection for the 5-stage pipeline. All request vectors
// are combinational from the current stage contents plus the mul/div tracker
// state; a flush of stage k suppresses every stall/extend at or below k.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int REG_W         = 5
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  logic     load_use;
  logic     redirect;
  logic     exc;
  logic     mem_ext;
  logic     md_ext;
  logic     md_busy_w;
  stg_vec_t flush_v;
  stg_vec_t kill_mask;
  stg_vec_t stall_v;
  stg_vec_t extend_v;

  // Load in EX feeding a source of ID; register 0 is hardwired and never hazards.
  assign load_use = hz.id_valid & hz.ex_valid & hz.ex_is_load &
                    (hz.ex_dest != REG_W'(0)) &
                    ((hz.ex_dest == hz.id_rs) |
                     (hz.id_uses_rt & (hz.ex_dest == hz.id_rt)));

  assign redirect = hz.ex_valid & hz.ex_redirect;
  assign exc      = hz.mem_valid & hz.mem_exc;

  // MEM wait-state. Only an exception flush reaches stage 3, so masking the
  // MEM extend needs nothing beyond the exception itself; keeping it scalar
  // also keeps the tracker's advance input free of the full vector.
  assign mem_ext  = hz.mem_valid & hz.mem_access & ~hz.mem_ready & ~hz.mem_exc;

  muldiv_tracker #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_muldiv_tracker (
    .clk     (clk),
    .rst     (rst),
    .start   (hz.ex_valid & hz.ex_muldiv),
    .advance (~mem_ext),
    .kill    (exc),
    .ext_req (md_ext),
    .busy    (md_busy_w)
  );

  // Assemble raw requests and apply flush priority.
  always_comb begin
    flush_v          = '0;
    flush_v[STG_ID]  = redirect;
    flush_v[STG_MEM] = exc;
    kill_mask        = flush_kill_mask(flush_v);

    stall_v          = '0;
    stall_v[STG_ID]  = load_use;
    stall_v          = stall_v & ~kill_mask;

    extend_v          = '0;
    extend_v[STG_EX]  = md_ext;
    extend_v[STG_MEM] = mem_ext;
    extend_v          = extend_v & ~kill_mask;
  end

  // Outputs are forced quiet for as long as reset is held, not just at the edge.
  assign hz.stall   = rst ? stall_v  : '0;
  assign hz.flush   = rst ? flush_v  : '0;
  assign hz.extend  = rst ? extend_v : '0;
  assign hz.md_busy = rst & md_busy_w;

endmodule
